// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, the EX/MEM stage state enum
// and the packed field bundle held by the EX/MEM pipeline latch.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FULL    = 2'd1,
      MEMWAIT = 2'd2
   } exmem_state_t;

   typedef struct packed {
      logic     valid;
      word_t    portOut;
      word_t    storedat;
      word_t    npc;
      logic     zero;
      logic     negative;
      logic     overflow;
      regbits_t wsel;
      logic     regwen;
      logic     dren;
      logic     dwen;
      logic     ovfchk;
   } exmem_fields_t;

endpackage

// File: rtl/ex_mem_latch_if.sv
// EX -> MEM pipeline latch bus. The master drives the EX-side fields and pipeline
// controls; the slave (the latch) returns the registered MEM-side copies.
interface ex_mem_latch_if;
   import cpu_types_pkg::*;

   // en requests an advance; the latch accepts only while busy is low and flush is low.
   logic         en, flush, dhit;
   logic         ex_valid, ex_zero, ex_negative, ex_overflow;
   logic         ex_regwen, ex_dren, ex_dwen, ex_ovfchk;
   word_t        ex_portOut, ex_storedat, ex_npc;
   regbits_t     ex_wsel;

   logic         mem_valid, mem_zero, mem_negative, mem_overflow;
   logic         mem_regwen, mem_dren, mem_dwen, mem_ovfchk;
   word_t        mem_portOut, mem_storedat, mem_npc;
   regbits_t     mem_wsel;
   logic         busy, ovf_trap;
   exmem_state_t state;

   modport master (
      output en, flush, dhit, ex_valid, ex_zero, ex_negative, ex_overflow,
             ex_regwen, ex_dren, ex_dwen, ex_ovfchk, ex_portOut, ex_storedat,
             ex_npc, ex_wsel,
      input  mem_valid, mem_zero, mem_negative, mem_overflow, mem_regwen,
             mem_dren, mem_dwen, mem_ovfchk, mem_portOut, mem_storedat, mem_npc,
             mem_wsel, busy, ovf_trap, state
   );

   modport slave (
      input  en, flush, dhit, ex_valid, ex_zero, ex_negative, ex_overflow,
             ex_regwen, ex_dren, ex_dwen, ex_ovfchk, ex_portOut, ex_storedat,
             ex_npc, ex_wsel,
      output mem_valid, mem_zero, mem_negative, mem_overflow, mem_regwen,
             mem_dren, mem_dwen, mem_ovfchk, mem_portOut, mem_storedat, mem_npc,
             mem_wsel, busy, ovf_trap, state
   );

endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with a memory-wait state that stalls upstream until dhit.
// Optional overflow trapping is enabled by defining EXMEM_OVF_TRAP_EN.
import cpu_types_pkg::*;

module ex_mem_latch (
   input  logic          CLK,
   input  logic          nRST,
   ex_mem_latch_if.slave bus
);

   exmem_state_t  state_q, state_d;
   exmem_fields_t fld_q, fld_d;
   logic          busy, load;
`ifdef EXMEM_OVF_TRAP_EN
   logic          trap_q, trap_d;
`endif

   always_comb begin
      // busy depends only on state and dhit so en/flush never loop back into it.
      busy    = (state_q == MEMWAIT) && !bus.dhit;
      load    = bus.en && !busy && !bus.flush;
      state_d = state_q;
      fld_d   = fld_q;
`ifdef EXMEM_OVF_TRAP_EN
      trap_d  = trap_q;
`endif
      if (bus.flush) begin
         fld_d.valid  = 1'b0;
         fld_d.regwen = 1'b0;
         fld_d.dren   = 1'b0;
         fld_d.dwen   = 1'b0;
         state_d      = EMPTY;
`ifdef EXMEM_OVF_TRAP_EN
         trap_d       = 1'b0;
`endif
      end else if (load) begin
         fld_d.valid    = bus.ex_valid;
         fld_d.portOut  = bus.ex_portOut;
         fld_d.storedat = bus.ex_storedat;
         fld_d.npc      = bus.ex_npc;
         fld_d.zero     = bus.ex_zero;
         fld_d.negative = bus.ex_negative;
         fld_d.overflow = bus.ex_overflow;
         fld_d.wsel     = bus.ex_wsel;
         fld_d.regwen   = bus.ex_regwen;
         fld_d.dren     = bus.ex_dren;
         fld_d.dwen     = bus.ex_dwen;
         fld_d.ovfchk   = bus.ex_ovfchk;
         if (!bus.ex_valid)                  state_d = EMPTY;
         else if (bus.ex_dren || bus.ex_dwen) state_d = MEMWAIT;
         else                                 state_d = FULL;
`ifdef EXMEM_OVF_TRAP_EN
         trap_d = 1'b0;
         // A trapping instruction must not write back or touch memory.
         if (bus.ex_valid && bus.ex_ovfchk && bus.ex_overflow) begin
            trap_d       = 1'b1;
            fld_d.regwen = 1'b0;
            fld_d.dren   = 1'b0;
            fld_d.dwen   = 1'b0;
            state_d      = FULL;
         end
`endif
      end else if ((state_q == MEMWAIT) && bus.dhit) begin
         fld_d.dren = 1'b0;
         fld_d.dwen = 1'b0;
         state_d    = FULL;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= EMPTY;
         fld_q   <= '0;
`ifdef EXMEM_OVF_TRAP_EN
         trap_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         fld_q   <= fld_d;
`ifdef EXMEM_OVF_TRAP_EN
         trap_q  <= trap_d;
`endif
      end
   end

   assign bus.mem_valid    = fld_q.valid;
   assign bus.mem_portOut  = fld_q.portOut;
   assign bus.mem_storedat = fld_q.storedat;
   assign bus.mem_npc      = fld_q.npc;
   assign bus.mem_zero     = fld_q.zero;
   assign bus.mem_negative = fld_q.negative;
   assign bus.mem_overflow = fld_q.overflow;
   assign bus.mem_wsel     = fld_q.wsel;
   assign bus.mem_regwen   = fld_q.regwen & fld_q.valid;
   assign bus.mem_dren     = fld_q.dren;
   assign bus.mem_dwen     = fld_q.dwen;
   assign bus.mem_ovfchk   = fld_q.ovfchk;
   assign bus.busy         = busy;
   assign bus.state        = state_q;
`ifdef EXMEM_OVF_TRAP_EN
   assign bus.ovf_trap     = trap_q;
`else
   assign bus.ovf_trap     = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed bench for ex_mem_latch: reset, ALU pass-through, hold, load/store waits,
// flush priority, invalid loads, overflow handling and asynchronous reset mid-wait.
import cpu_types_pkg::*;

module tb_ex_mem_latch;

   logic CLK = 1'b0;
   logic nRST;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] exp_q[$];

   ex_mem_latch_if bus ();

   ex_mem_latch dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] wsel,
                        input logic rw, input logic dr, input logic dw,
                        input logic ovc, input logic ovf);
      bus.ex_valid    = v;
      bus.ex_portOut  = res;
      bus.ex_storedat = ~res;
      bus.ex_npc      = res + 32'd4;
      bus.ex_zero     = (res == 32'd0);
      bus.ex_negative = res[31];
      bus.ex_overflow = ovf;
      bus.ex_wsel     = wsel;
      bus.ex_regwen   = rw;
      bus.ex_dren     = dr;
      bus.ex_dwen     = dw;
      bus.ex_ovfchk   = ovc;
   endtask

   initial begin
      nRST      = 1'b0;
      bus.en    = 1'b0;
      bus.flush = 1'b0;
      bus.dhit  = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("rst_portOut", bus.mem_portOut, 32'h0);
      check("rst_valid",   32'(bus.mem_valid), 32'h0);
      check("rst_state",   32'(bus.state), 32'(EMPTY));
      check("rst_busy",    32'(bus.busy), 32'h0);
      check("rst_trap",    32'(bus.ovf_trap), 32'h0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;

      // ALU result passes through in one cycle
      drive(1'b1, 32'h0000_0010, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.en = 1'b1;
      step();
      check("alu_portOut",  bus.mem_portOut, 32'h10);
      check("alu_storedat", bus.mem_storedat, 32'hFFFF_FFEF);
      check("alu_npc",      bus.mem_npc, 32'h14);
      check("alu_wsel",     32'(bus.mem_wsel), 32'd5);
      check("alu_regwen",   32'(bus.mem_regwen), 32'd1);
      check("alu_valid",    32'(bus.mem_valid), 32'd1);
      check("alu_busy",     32'(bus.busy), 32'd0);
      check("alu_state",    32'(bus.state), 32'(FULL));

      // Hold with en low
      drive(1'b1, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("hold_neg", 32'(bus.mem_negative), 32'd1);
      bus.en = 1'b0;
      drive(1'b1, 32'h1234_5678, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) exp_q.push_back(32'hDEAD_BEEF);
      while (exp_q.size() > 0) begin
         step();
         check("hold_portOut", bus.mem_portOut, exp_q.pop_front());
      end
      check("hold_state", 32'(bus.state), 32'(FULL));

      // Load word: three wait cycles, then dhit with en low
      drive(1'b1, 32'h0000_0100, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      bus.en = 1'b1;
      bus.dhit = 1'b0;
      step();
      check("lw_state", 32'(bus.state), 32'(MEMWAIT));
      check("lw_dren",  32'(bus.mem_dren), 32'd1);
      drive(1'b1, 32'h0000_0200, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("lw_busy", 32'(bus.busy), 32'd1);
         step();
         check("lw_stall_portOut", bus.mem_portOut, 32'h100);
      end
      bus.dhit = 1'b1;
      bus.en   = 1'b0;
      #1;
      check("lw_busy_hit", 32'(bus.busy), 32'd0);
      step();
      bus.dhit = 1'b0;
      check("lw_done_state",  32'(bus.state), 32'(FULL));
      check("lw_done_dren",   32'(bus.mem_dren), 32'd0);
      check("lw_done_portOut", bus.mem_portOut, 32'h100);
      check("lw_done_regwen", 32'(bus.mem_regwen), 32'd1);

      // Store: dhit and load in the same cycle capture the next instruction
      drive(1'b1, 32'h0000_0300, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.en = 1'b1;
      step();
      check("sw_dwen", 32'(bus.mem_dwen), 32'd1);
      drive(1'b1, 32'h0000_0400, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.dhit = 1'b1;
      #1;
      check("sw_busy_hit", 32'(bus.busy), 32'd0);
      step();
      bus.dhit = 1'b0;
      check("sw_next_portOut", bus.mem_portOut, 32'h400);
      check("sw_next_dwen",    32'(bus.mem_dwen), 32'd0);
      check("sw_next_state",   32'(bus.state), 32'(FULL));

      // Flush beats en and dhit during MEMWAIT
      drive(1'b1, 32'h0000_0500, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("fl_state_pre", 32'(bus.state), 32'(MEMWAIT));
      drive(1'b1, 32'h0000_0600, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.dhit  = 1'b1;
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      bus.dhit  = 1'b0;
      check("fl_valid",   32'(bus.mem_valid), 32'd0);
      check("fl_dren",    32'(bus.mem_dren), 32'd0);
      check("fl_regwen",  32'(bus.mem_regwen), 32'd0);
      check("fl_state",   32'(bus.state), 32'(EMPTY));
      check("fl_portOut", bus.mem_portOut, 32'h500);
      check("fl_busy",    32'(bus.busy), 32'd0);

      // Bubble: regwen is qualified by valid
      drive(1'b0, 32'h0000_0700, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("bub_state",   32'(bus.state), 32'(EMPTY));
      check("bub_valid",   32'(bus.mem_valid), 32'd0);
      check("bub_regwen",  32'(bus.mem_regwen), 32'd0);
      check("bub_portOut", bus.mem_portOut, 32'h700);

      // Signed overflow
      drive(1'b1, 32'h8000_0000, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      check("ovf_passthru", 32'(bus.mem_overflow), 32'd1);
      check("ovf_ovfchk",   32'(bus.mem_ovfchk), 32'd1);
      check("ovf_state",    32'(bus.state), 32'(FULL));
`ifdef EXMEM_OVF_TRAP_EN
      check("ovf_trap",   32'(bus.ovf_trap), 32'd1);
      check("ovf_regwen", 32'(bus.mem_regwen), 32'd0);
`else
      check("ovf_trap",   32'(bus.ovf_trap), 32'd0);
      check("ovf_regwen", 32'(bus.mem_regwen), 32'd1);
`endif
      drive(1'b1, 32'h0000_0900, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("ovf_clr_trap",   32'(bus.ovf_trap), 32'd0);
      check("ovf_clr_regwen", 32'(bus.mem_regwen), 32'd1);
      check("ovf_clr_flag",   32'(bus.mem_overflow), 32'd0);

      // Asynchronous reset in the middle of a memory wait
      drive(1'b1, 32'h0000_0A00, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      bus.en = 1'b0;
      check("rw_busy_pre", 32'(bus.busy), 32'd1);
      #2;
      nRST = 1'b0;
      #1;
      check("rw_portOut", bus.mem_portOut, 32'h0);
      check("rw_wsel",    32'(bus.mem_wsel), 32'd0);
      check("rw_dren",    32'(bus.mem_dren), 32'd0);
      check("rw_valid",   32'(bus.mem_valid), 32'd0);
      check("rw_state",   32'(bus.state), 32'(EMPTY));
      check("rw_busy",    32'(bus.busy), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      step();
      check("rw_busy_post",  32'(bus.busy), 32'd0);
      check("rw_state_post", 32'(bus.state), 32'(EMPTY));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
